// File: rtl/sda_gmem_rd_arbiter.sv
// Round-robin arbiter sharing the kernel's single m_axi_gmem read channel (AR+R) among NUM_REQ requesters.
// Optional beat-count checker enabled by defining SDA_GMEM_ARB_BEAT_CHECK_EN.
module sda_gmem_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]          req_arlen,
  output logic [NUM_REQ-1:0]            req_arready,
  output logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [1:0]                    req_rresp,
  output logic                          req_rlast,
  output logic [ADDR_WIDTH-1:0]         m_axi_gmem_ARADDR,
  output logic [7:0]                    m_axi_gmem_ARLEN,
  output logic [2:0]                    m_axi_gmem_ARSIZE,
  output logic [1:0]                    m_axi_gmem_ARBURST,
  output logic                          m_axi_gmem_ARVALID,
  input  logic                          m_axi_gmem_ARREADY,
  input  logic [DATA_WIDTH-1:0]         m_axi_gmem_RDATA,
  input  logic [1:0]                    m_axi_gmem_RRESP,
  input  logic                          m_axi_gmem_RLAST,
  input  logic                          m_axi_gmem_RVALID,
  output logic                          m_axi_gmem_RREADY,
  output logic                          busy,
  output logic [2:0]                    grant_id,
  output logic                          burst_err
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [IDW-1:0]           gid;
  logic [2*NUM_REQ-1:0]     req_dbl;
  logic [NUM_REQ-1:0]       req_rot;
  logic                     found;
  logic [2:0]               win;
  logic [3:0]               sum;
  logic                     ar_hs, r_hs, last_hs;

  assign gid     = grant_id[IDW-1:0];
  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit then wins.
  assign req_dbl = {req_arvalid, req_arvalid} >> rr_ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found = 1'b1;
        sum   = 4'(rr_ptr) + 4'(k);
        win   = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
      end
    end
  end

  assign ar_hs   = m_axi_gmem_ARVALID & m_axi_gmem_ARREADY;
  assign r_hs    = m_axi_gmem_RVALID & m_axi_gmem_RREADY;
  assign last_hs = r_hs & m_axi_gmem_RLAST;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = win;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) state_nxt = DATA;
      end
      DATA: begin
        if (last_hs) begin
          rr_ptr_nxt = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      grant_id <= 3'd0;
      rr_ptr   <= 3'd0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  always_comb begin
    m_axi_gmem_ARVALID = 1'b0;
    m_axi_gmem_ARADDR  = '0;
    m_axi_gmem_ARLEN   = '0;
    m_axi_gmem_RREADY  = 1'b0;
    req_arready        = '0;
    req_rvalid         = '0;
    case (state)
      ADDR: begin
        m_axi_gmem_ARVALID = 1'b1;
        m_axi_gmem_ARADDR  = req_araddr[int'(gid)*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_gmem_ARLEN   = req_arlen[int'(gid)*8 +: 8];
        if (m_axi_gmem_ARREADY) req_arready = ONE_HOT0 << gid;
      end
      DATA: begin
        m_axi_gmem_RREADY = req_rready[gid];
        if (m_axi_gmem_RVALID) req_rvalid = ONE_HOT0 << gid;
      end
      default: ;
    endcase
  end

  assign m_axi_gmem_ARSIZE  = AR_SIZE;
  assign m_axi_gmem_ARBURST = 2'b01;
  assign req_rdata          = m_axi_gmem_RDATA;
  assign req_rresp          = m_axi_gmem_RRESP;
  assign req_rlast          = m_axi_gmem_RLAST;
  assign busy               = (state != IDLE);

`ifdef SDA_GMEM_ARB_BEAT_CHECK_EN
  logic [7:0] beat_cnt;
  logic       burst_err_q;

  // Counter holds beats remaining after the current one; RLAST must coincide with zero.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      beat_cnt    <= 8'd0;
      burst_err_q <= 1'b0;
    end else if (ar_hs) begin
      beat_cnt <= m_axi_gmem_ARLEN;
    end else if (r_hs) begin
      if (m_axi_gmem_RLAST != (beat_cnt == 8'd0)) burst_err_q <= 1'b1;
      if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
    end
  end

  assign burst_err = burst_err_q;
`else
  assign burst_err = 1'b0;
`endif

endmodule
